// File: rtl/sign_extend.sv
// 16-to-32-bit immediate extender with a combinational result and a
// 1-cycle registered copy qualified by Valid_In.
module sign_extend (
  input  logic        clk,
  input  logic        reset,
  input  logic        Zero_Extend,
  input  logic [15:0] In,
  input  logic        Valid_In,
  output logic [31:0] Out,
  output logic        Sign,
  output logic [31:0] Out_Reg,
  output logic        Valid_Out
);

  // Fill bit for the upper half: the sign bit, or zero when zero-extending.
  logic fill;
  assign fill = In[15] & ~Zero_Extend;
  assign Sign = fill;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_ext
      assign Out[gi]      = In[gi];
      assign Out[gi + 16] = fill;
    end
  endgenerate

  // Out_Reg holds its last value across invalid cycles; Valid_Out always follows Valid_In.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Out_Reg   <= 32'h0000_0000;
      Valid_Out <= 1'b0;
    end else begin
      Valid_Out <= Valid_In;
      if (Valid_In) begin
        Out_Reg <= Out;
      end
    end
  end

endmodule

// File: tb/tb_sign_extend.sv
// Directed bench for sign_extend: combinational extension vectors, the
// registered path with hold/valid behaviour, and asynchronous reset.
module tb_sign_extend;

  logic        clk;
  logic        reset;
  logic        Zero_Extend;
  logic [15:0] In;
  logic        Valid_In;
  logic [31:0] Out;
  logic        Sign;
  logic [31:0] Out_Reg;
  logic        Valid_Out;

  int checks   = 0;
  int failures = 0;

  sign_extend dut (
    .clk        (clk),
    .reset      (reset),
    .Zero_Extend(Zero_Extend),
    .In         (In),
    .Valid_In   (Valid_In),
    .Out        (Out),
    .Sign       (Sign),
    .Out_Reg    (Out_Reg),
    .Valid_Out  (Valid_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed vectors: input, zero-extend flag, expected Out, expected Sign.
  localparam int NV = 10;
  logic [15:0] v_in  [NV] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF,
                              16'hFFFF, 16'h1234, 16'hA5A5, 16'h5A5A, 16'h0001};
  logic        v_ze  [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] v_out [NV] = '{32'hFFFF8000, 32'h00008000, 32'h00007FFF, 32'h00000000, 32'hFFFFFFFF,
                              32'h0000FFFF, 32'h00001234, 32'hFFFFA5A5, 32'h00005A5A, 32'h00000001};
  logic        v_sgn [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    Valid_In    = 1'b0;
    Zero_Extend = 1'b0;
    In          = 16'h0000;

    // Reset must clear the registered outputs before any clock edge.
    #2;
    chk("rst_out_reg_async", Out_Reg, 32'h0);
    chk("rst_valid_async", {31'b0, Valid_Out}, 32'h0);

    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_out_reg", Out_Reg, 32'h0);
    chk("idle_valid", {31'b0, Valid_Out}, 32'h0);

    // Back-to-back valid vectors; each negedge sees the new Out and the previous vector in Out_Reg.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      In = v_in[i]; Zero_Extend = v_ze[i]; Valid_In = 1'b1;
      @(negedge clk);
      chk($sformatf("out_v%0d", i), Out, v_out[i]);
      chk($sformatf("sign_v%0d", i), {31'b0, Sign}, {31'b0, v_sgn[i]});
      if (i == 0) begin
        chk("first_valid_out", {31'b0, Valid_Out}, 32'h0);
      end else begin
        chk($sformatf("out_reg_v%0d", i), Out_Reg, v_out[i-1]);
        chk($sformatf("valid_v%0d", i), {31'b0, Valid_Out}, 32'h1);
      end
      $display("vec %0d In=%h ZE=%0b Out=%h Sign=%0b Out_Reg=%h Valid_Out=%0b",
               i, In, Zero_Extend, Out, Sign, Out_Reg, Valid_Out);
    end

    // Registered path: load 8001, then hold with Valid_In low.
    @(posedge clk); #1;
    In = 16'h8001; Zero_Extend = 1'b0; Valid_In = 1'b1;
    @(negedge clk);
    chk("out_8001", Out, 32'hFFFF8001);
    chk("out_reg_last_vec", Out_Reg, 32'h00000001);
    @(posedge clk); #1;
    In = 16'h0042; Valid_In = 1'b0;
    @(negedge clk);
    chk("out_reg_8001", Out_Reg, 32'hFFFF8001);
    chk("valid_8001", {31'b0, Valid_Out}, 32'h1);
    chk("out_0042", Out, 32'h00000042);
    @(posedge clk); #1;
    @(negedge clk);
    chk("out_reg_hold", Out_Reg, 32'hFFFF8001);
    chk("valid_drop", {31'b0, Valid_Out}, 32'h0);
    $display("hold Out_Reg=%h Valid_Out=%0b", Out_Reg, Valid_Out);

    // Mid-operation reset between edges: registers clear at once, Out keeps tracking.
    Valid_In = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_out_reg", Out_Reg, 32'h00000042);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out_reg", Out_Reg, 32'h0);
    chk("midrst_valid", {31'b0, Valid_Out}, 32'h0);
    chk("midrst_out", Out, 32'h00000042);
    In = 16'hC000;
    #1;
    chk("midrst_out_c000", Out, 32'hFFFFC000);
    chk("midrst_sign_c000", {31'b0, Sign}, 32'h1);
    @(posedge clk); #1;
    chk("rst_held_out_reg", Out_Reg, 32'h0);
    chk("rst_held_valid", {31'b0, Valid_Out}, 32'h0);
    $display("reset Out=%h Out_Reg=%h Valid_Out=%0b", Out, Out_Reg, Valid_Out);

    // First valid edge after reset release produces data one cycle later.
    @(negedge clk);
    reset = 1'b0; In = 16'h00FF; Zero_Extend = 1'b1; Valid_In = 1'b1;
    @(posedge clk); #1;
    Valid_In = 1'b0;
    @(negedge clk);
    chk("post_rst_out_reg", Out_Reg, 32'h000000FF);
    chk("post_rst_valid", {31'b0, Valid_Out}, 32'h1);
    $display("post-reset Out_Reg=%h Valid_Out=%0b", Out_Reg, Valid_Out);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
